hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit_pkg.sv | 38 +++
 rtl/hazard_unit_reg_usage_decode.sv | 48 ++++
 rtl/hazard_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: opcode/funct codes, forward-select codes and the pipeline tracking entry,
// shared between the hazard unit and the controller.
package hazard_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    typedef struct packed {
        logic [4:0] dst;
        logic       wr;
        logic       is_load;
    } trk_t;

    // A producer only matters for a source that is actually read and is not $0.
    function automatic logic src_hit(input trk_t t, input logic used, input logic [4:0] r);
        return used && t.wr && (r != 5'd0) && (t.dst == r);
    endfunction

endpackage

// File: rtl/hazard_unit_reg_usage_decode.sv
// reg_usage_decode: classifies the decode-stage instruction into destination and source
// register usage for hazard detection.
module reg_usage_decode
    import hazard_unit_pkg::*;
(
    input  logic [31:0] i_inst,
    output logic [4:0]  o_dst,
    output logic        o_wr,
    output logic        o_is_load,
    output logic        o_uses_rs,
    output logic        o_uses_rt,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_r;
    logic       w_jr;
    logic       w_shift;
    logic       w_alu_i;
    logic       w_load;
    logic       w_store;
    logic       w_branch;
    logic       w_unused;

    assign w_op     = i_inst[31:26];
    assign w_fn     = i_inst[5:0];
    assign w_r      = w_op == OP_RTYPE;
    assign w_jr     = w_r && (w_fn == FN_JR);
    assign w_shift  = w_r && (w_fn == FN_SLL || w_fn == FN_SRL || w_fn == FN_SRA);
    assign w_alu_i  = w_op == OP_ADDI || w_op == OP_ANDI || w_op == OP_ORI || w_op == OP_SLTI;
    assign w_load   = w_op == OP_LW || w_op == OP_LB;
    assign w_store  = w_op == OP_SW;
    assign w_branch = w_op == OP_BEQ || w_op == OP_BNE;

    assign o_dst     = (w_r && !w_jr) ? i_inst[15:11] :
                       (w_alu_i || w_op == OP_LUI || w_load) ? i_inst[20:16] :
                       (w_op == OP_JAL) ? 5'd31 : 5'd0;
    assign o_wr      = o_dst != 5'd0;
    assign o_is_load = w_load;
    assign o_uses_rs = (w_r && !w_shift) || w_alu_i || w_load || w_store || w_branch;
    assign o_uses_rt = w_r || w_store || w_branch;
    assign o_rs      = i_inst[25:21];
    assign o_rt      = i_inst[20:16];
    assign w_unused  = ^i_inst[10:6];

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / RAW stall, forward-select and redirect-flush generation.
// Define FORWARDING_EN to enable forwarding; otherwise RAW hazards stall until the producer leaves MEM.
module hazard_unit
    import hazard_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_id_inst,
    input  logic        i_id_valid,
    input  logic        i_redirect,
    output logic        o_stall,
    output logic        o_flush,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b
);

    logic [4:0] w_dst;
    logic       w_wr;
    logic       w_is_load;
    logic       w_uses_rs;
    logic       w_uses_rt;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_hazard;
    logic       w_bubble;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_unused;
    trk_t       r_ex;
    trk_t       r_mem;
    trk_t       r_wb;
    logic       r_flush;
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    reg_usage_decode u_dec (
        .i_inst    (i_id_inst),
        .o_dst     (w_dst),
        .o_wr      (w_wr),
        .o_is_load (w_is_load),
        .o_uses_rs (w_uses_rs),
        .o_uses_rt (w_uses_rt),
        .o_rs      (w_rs),
        .o_rt      (w_rt)
    );

`ifdef FORWARDING_EN
    assign w_hazard = r_ex.is_load && (src_hit(r_ex, w_uses_rs, w_rs) || src_hit(r_ex, w_uses_rt, w_rt));
    // r_ex is about to move into MEM, r_mem into WB; the nearer producer wins.
    assign w_fwd_a  = w_bubble ? FWD_RF : src_hit(r_ex, w_uses_rs, w_rs) ? FWD_MEM :
                      src_hit(r_mem, w_uses_rs, w_rs) ? FWD_WB : FWD_RF;
    assign w_fwd_b  = w_bubble ? FWD_RF : src_hit(r_ex, w_uses_rt, w_rt) ? FWD_MEM :
                      src_hit(r_mem, w_uses_rt, w_rt) ? FWD_WB : FWD_RF;
`else
    assign w_hazard = src_hit(r_ex, w_uses_rs, w_rs) || src_hit(r_ex, w_uses_rt, w_rt) ||
                      src_hit(r_mem, w_uses_rs, w_rs) || src_hit(r_mem, w_uses_rt, w_rt);
    assign w_fwd_a  = FWD_RF;
    assign w_fwd_b  = FWD_RF;
`endif

    // The instruction under flush is dead: it neither stalls nor produces.
    assign o_stall  = i_id_valid && !r_flush && w_hazard;
    assign w_bubble = o_stall || r_flush || !i_id_valid;
    assign o_flush  = r_flush;
    assign o_fwd_a  = r_fwd_a;
    assign o_fwd_b  = r_fwd_b;
    assign w_unused = ^{r_wb, r_mem.is_load, r_ex.is_load};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_wb    <= '0;
            r_flush <= 1'b0;
            r_fwd_a <= FWD_RF;
            r_fwd_b <= FWD_RF;
        end else begin
            r_ex    <= w_bubble ? '0 : '{dst: w_dst, wr: w_wr, is_load: w_is_load};
            r_mem   <= r_ex;
            r_wb    <= r_mem;
            r_flush <= i_redirect && !o_stall && !r_flush;
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;
        end
    end

endmodule
